// File: rtl/addr_split_parser_pkg.sv
// Shared constants for the registered cache address splitter: derived field
// widths and output-register state encodings.
package addr_split_parser_pkg;

  localparam logic [1:0] ST_EMPTY     = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_HOLD_PEND = 2'd2;

  function automatic int line_bytes(input int off_w);
    return 1 << off_w;
  endfunction

  function automatic int idx_w(input int cap_w, input int ways, input int off_w);
    return cap_w - $clog2(ways) - off_w;
  endfunction

  function automatic int tag_w(input int addr_w, input int cap_w, input int ways,
                               input int off_w);
    return addr_w - idx_w(cap_w, ways, off_w) - off_w;
  endfunction

endpackage

// File: rtl/addr_split_parser_fields.sv
// Combinational split of a byte address into cache tag, set index and line offset.
module addr_split_parser_fields
  import addr_split_parser_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int OFF_W  = 6,
  parameter int CAP_W  = 14,
  parameter int WAYS   = 8
) (
  input  logic [ADDR_W-1:0]                               addr_i,
  output logic [tag_w(ADDR_W, CAP_W, WAYS, OFF_W)-1:0]    tag_o,
  output logic [idx_w(CAP_W, WAYS, OFF_W)-1:0]            index_o,
  output logic [OFF_W-1:0]                                offset_o
);

  localparam int IDX_W = idx_w(CAP_W, WAYS, OFF_W);

  assign offset_o = addr_i[OFF_W-1:0];
  assign index_o  = addr_i[IDX_W+OFF_W-1:OFF_W];
  assign tag_o    = addr_i[ADDR_W-1:IDX_W+OFF_W];

endmodule

// File: rtl/addr_split_parser.sv
// Registered, handshaked cache address splitter: one access in, one or two
// line-local pieces out, with same-line detection and saturating statistics.
module addr_split_parser
  import addr_split_parser_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int OFF_W  = 6,
  parameter int CAP_W  = 14,
  parameter int WAYS   = 8,
  parameter int CNT_W  = 32
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [ADDR_W-1:0]                               in_addr,
  input  logic [OFF_W:0]                                  in_len,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [tag_w(ADDR_W, CAP_W, WAYS, OFF_W)-1:0]    out_tag,
  output logic [idx_w(CAP_W, WAYS, OFF_W)-1:0]            out_index,
  output logic [OFF_W-1:0]                                out_offset,
  output logic [OFF_W:0]                                  out_len,
  output logic                                            out_first,
  output logic                                            out_last,
  output logic                                            out_same_line,
  output logic                                            err,
  output logic [CNT_W-1:0]                                stat_accesses,
  output logic [CNT_W-1:0]                                stat_splits
);

  localparam int IDX_W = idx_w(CAP_W, WAYS, OFF_W);
  localparam int TAG_W = tag_w(ADDR_W, CAP_W, WAYS, OFF_W);
  localparam int LN_W  = ADDR_W - OFF_W;
  localparam logic [OFF_W:0] LINE = {1'b1, {OFF_W{1'b0}}};

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
    logic [OFF_W:0]   len;
    logic             first;
    logic             last;
  } piece_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]             state_q, state_d;
  piece_t                 piece_q, piece_d;
  logic                   same_q, same_d;
  logic [TAG_W+IDX_W-1:0] hist_q, hist_d;
  logic                   hist_vld_q, hist_vld_d;
  logic [LN_W-1:0]        pend_line_q, pend_line_d;
  logic [OFF_W:0]         pend_len_q, pend_len_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]       split_cnt_q, split_cnt_d;

  logic [TAG_W-1:0] in_tag, p2_tag;
  logic [IDX_W-1:0] in_idx, p2_idx;
  logic [OFF_W-1:0] in_off, p2_off;

  addr_split_parser_fields #(
    .ADDR_W(ADDR_W), .OFF_W(OFF_W), .CAP_W(CAP_W), .WAYS(WAYS)
  ) u_in_fields (
    .addr_i(in_addr), .tag_o(in_tag), .index_o(in_idx), .offset_o(in_off)
  );

  // Second piece always starts at a line base, so its offset field is zero.
  addr_split_parser_fields #(
    .ADDR_W(ADDR_W), .OFF_W(OFF_W), .CAP_W(CAP_W), .WAYS(WAYS)
  ) u_p2_fields (
    .addr_i({pend_line_q, {OFF_W{1'b0}}}), .tag_o(p2_tag), .index_o(p2_idx),
    .offset_o(p2_off)
  );

  logic           vld, hs, accept, legal, split;
  logic [OFF_W:0] rem;

  assign vld      = (state_q != ST_EMPTY);
  assign hs       = vld && out_ready;
  assign in_ready = (state_q == ST_EMPTY) || ((state_q == ST_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign legal    = (in_len != '0) && (in_len <= LINE);
  assign rem      = LINE - {1'b0, in_off};
  assign split    = in_len > rem;

  always_comb begin
    state_d     = state_q;
    piece_d     = piece_q;
    same_d      = same_q;
    hist_d      = hist_q;
    hist_vld_d  = hist_vld_q;
    pend_line_d = pend_line_q;
    pend_len_d  = pend_len_q;
    acc_cnt_d   = acc_cnt_q;
    split_cnt_d = split_cnt_q;
    err_d       = 1'b0;

    if (hs) begin
      if (state_q == ST_HOLD_PEND) begin
        piece_d    = '{tag: p2_tag, index: p2_idx, offset: p2_off, len: pend_len_q,
                       first: 1'b0, last: 1'b1};
        same_d     = 1'b0;
        hist_d     = {p2_tag, p2_idx};
        hist_vld_d = 1'b1;
        state_d    = ST_HOLD;
      end else begin
        state_d = ST_EMPTY;
      end
    end

    // Accept can only coincide with a non-pending handshake, never with piece 2.
    if (accept) begin
      if (legal) begin
        piece_d     = '{tag: in_tag, index: in_idx, offset: in_off,
                        len: split ? rem : in_len, first: 1'b1, last: !split};
        same_d      = hist_vld_q && ({in_tag, in_idx} == hist_q);
        hist_d      = {in_tag, in_idx};
        hist_vld_d  = 1'b1;
        pend_line_d = in_addr[ADDR_W-1:OFF_W] + LN_W'(1);
        pend_len_d  = in_len - rem;
        state_d     = split ? ST_HOLD_PEND : ST_HOLD;
        acc_cnt_d   = sat_inc(acc_cnt_q);
        if (split) split_cnt_d = sat_inc(split_cnt_q);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      piece_q     <= '0;
      same_q      <= 1'b0;
      hist_q      <= '0;
      hist_vld_q  <= 1'b0;
      pend_line_q <= '0;
      pend_len_q  <= '0;
      err_q       <= 1'b0;
      acc_cnt_q   <= '0;
      split_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      piece_q     <= piece_d;
      same_q      <= same_d;
      hist_q      <= hist_d;
      hist_vld_q  <= hist_vld_d;
      pend_line_q <= pend_line_d;
      pend_len_q  <= pend_len_d;
      err_q       <= err_d;
      acc_cnt_q   <= acc_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign out_valid     = vld;
  assign out_tag       = piece_q.tag;
  assign out_index     = piece_q.index;
  assign out_offset    = piece_q.offset;
  assign out_len       = piece_q.len;
  assign out_first     = piece_q.first;
  assign out_last      = piece_q.last;
  assign out_same_line = same_q;
  assign err           = err_q;
  assign stat_accesses = acc_cnt_q;
  assign stat_splits   = split_cnt_q;

endmodule
